reg_bus_arbiter: RTL and testbench

- Shares the single 6-bit-address, 8-bit-data register access bus (read/write strobes, addr, data_write, data_read) between two masters.
- Master 0 is the SPI instruction decoder path. Master 1 is an internal requester, for example a PWM shadow-update/status engine.
- Round-robin arbitration, one access per grant, per-master completion handshake.
- Sits between the masters and the register file.

---
 rtl/reg_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the shared register access bus.
// Each grant carries exactly one read or write. The granted master sees a
// one-cycle done pulse. All outputs are registered.
module reg_bus_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    state_t            state, state_nx;
    logic              sel, sel_nx;        // granted master: 0 or 1
    logic              rr, rr_nx;          // master favoured on contention
    logic [1:0]        cnt, cnt_nx;        // read-latency edge counter
    logic              m0_gnt_nx, m1_gnt_nx, m0_done_nx, m1_done_nx;
    logic [DATA_W-1:0] m0_rdata_nx, m1_rdata_nx;
    logic              read_nx, write_nx, busy_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_write_nx;
    logic              pick, we_sel, finish, capture;

    // Next-state and next-output logic. Every output is computed here one
    // cycle ahead, so all outputs leave the design directly from flops.
    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        rr_nx         = rr;
        cnt_nx        = cnt;
        m0_gnt_nx     = m0_gnt;
        m1_gnt_nx     = m1_gnt;
        m0_done_nx    = 1'b0;
        m1_done_nx    = 1'b0;
        m0_rdata_nx   = m0_rdata;
        m1_rdata_nx   = m1_rdata;
        read_nx       = 1'b0;
        write_nx      = 1'b0;
        addr_nx       = '0;
        data_write_nx = '0;
        pick          = 1'b0;
        we_sel        = 1'b0;
        finish        = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // A lone requester wins. On contention the pointer decides.
                    pick          = m1_req & (~m0_req | rr);
                    we_sel        = pick ? m1_we : m0_we;
                    sel_nx        = pick;
                    m0_gnt_nx     = ~pick;
                    m1_gnt_nx     = pick;
                    write_nx      = we_sel;
                    read_nx       = ~we_sel;
                    addr_nx       = pick ? m1_addr : m0_addr;
                    data_write_nx = we_sel ? (pick ? m1_wdata : m0_wdata) : '0;
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                if (read && RD_LATENCY != 0) begin
                    addr_nx  = addr;
                    cnt_nx   = 2'd1;
                    state_nx = WAIT;
                end else begin
                    capture = read;
                    finish  = 1'b1;
                end
            end
            WAIT: begin
                addr_nx = addr;
                if (cnt == LAT) begin
                    addr_nx = '0;
                    capture = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            DONE: begin
                m0_gnt_nx = 1'b0;
                m1_gnt_nx = 1'b0;
                rr_nx     = ~sel;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (finish) begin
            state_nx   = DONE;
            m0_done_nx = ~sel;
            m1_done_nx = sel;
        end
        if (capture) begin
            if (sel) m1_rdata_nx = data_read;
            else     m0_rdata_nx = data_read;
        end
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers. A reset clears everything, including any
    // access in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 1'b0;
            rr         <= 1'b0;
            cnt        <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            rr         <= rr_nx;
            cnt        <= cnt_nx;
            m0_gnt     <= m0_gnt_nx;
            m1_gnt     <= m1_gnt_nx;
            m0_done    <= m0_done_nx;
            m1_done    <= m1_done_nx;
            m0_rdata   <= m0_rdata_nx;
            m1_rdata   <= m1_rdata_nx;
            read       <= read_nx;
            write      <= write_nx;
            addr       <= addr_nx;
            data_write <= data_write_nx;
            busy       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter. The main instance uses RD_LATENCY=2.
// A second instance with RD_LATENCY=0 covers the combinational-read path.
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [5:0] m0_addr = 0, m1_addr = 0, addr;
    logic [7:0] m0_wdata = 0, m1_wdata = 0, data_read = 0;
    logic       m0_gnt, m0_done, m1_gnt, m1_done, read, write, busy;
    logic [7:0] m0_rdata, m1_rdata, data_write;

    // RD_LATENCY=0 instance
    logic       z_req = 0, z_we = 0;
    logic [5:0] z_addr = 0, z_addr_o;
    logic [7:0] z_wdata = 0, z_data_read = 0;
    logic       z_m0_gnt, z_m0_done, z_m1_gnt, z_m1_done, z_read, z_write, z_busy;
    logic [7:0] z_m0_rdata, z_m1_rdata, z_data_write;

    int nvec = 0;
    int nerr = 0;

    wire [36:0] all_out = {m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
                           read, write, addr, data_write, busy};

    reg_bus_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .read(read), .write(write), .addr(addr), .data_write(data_write),
        .data_read(data_read), .busy(busy)
    );

    reg_bus_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LATENCY(0)) dut_z (
        .clk(clk), .rst(rst),
        .m0_req(z_req), .m0_we(z_we), .m0_addr(z_addr), .m0_wdata(z_wdata),
        .m0_gnt(z_m0_gnt), .m0_done(z_m0_done), .m0_rdata(z_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(6'd0), .m1_wdata(8'd0),
        .m1_gnt(z_m1_gnt), .m1_done(z_m1_done), .m1_rdata(z_m1_rdata),
        .read(z_read), .write(z_write), .addr(z_addr_o), .data_write(z_data_write),
        .data_read(z_data_read), .busy(z_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_outputs", 64'(all_out), 0);

        // single write from m0
        m0_req = 1; m0_we = 1; m0_addr = 6'h05; m0_wdata = 8'hA5;
        tick();
        chk("w_write", 64'(write), 1);
        chk("w_read", 64'(read), 0);
        chk("w_addr", 64'(addr), 'h05);
        chk("w_wdata", 64'(data_write), 'hA5);
        chk("w_gnt", 64'({m0_gnt, m1_gnt}), 'b10);
        chk("w_busy", 64'(busy), 1);
        tick();
        chk("w_done", 64'({m0_done, m1_done}), 'b10);
        chk("w_bus_idle", 64'({read, write, addr, data_write}), 0);
        chk("w_gnt_hold", 64'(m0_gnt), 1);
        m0_req = 0;
        tick();
        chk("w_end", 64'({m0_gnt, m0_done, m1_gnt, m1_done, busy}), 0);

        // m1 read, data appears two edges after the strobe cycle
        m1_req = 1; m1_we = 0; m1_addr = 6'h10; data_read = 8'h00;
        tick();
        chk("r_strobe", 64'({read, write}), 'b10);
        chk("r_addr", 64'(addr), 'h10);
        chk("r_wdata0", 64'(data_write), 0);
        chk("r_gnt", 64'({m0_gnt, m1_gnt}), 'b01);
        tick();
        chk("r_wait1", 64'({read, write, m1_done}), 0);
        chk("r_wait1_addr", 64'(addr), 'h10);
        tick();
        chk("r_wait2", 64'({m1_done, m1_rdata}), 0);
        chk("r_wait2_addr", 64'(addr), 'h10);
        data_read = 8'h3C;
        tick();
        chk("r_done", 64'({m0_done, m1_done}), 'b01);
        chk("r_rdata", 64'(m1_rdata), 'h3C);
        chk("r_done_addr", 64'(addr), 0);
        m1_req = 0; data_read = 8'h77;
        tick();
        chk("r_end", 64'({m1_gnt, m1_done, busy}), 0);
        tick();
        chk("r_hold", 64'(m1_rdata), 'h3C);

        // reset before contention: rdata cleared, pointer back to m0
        rst = 1;
        tick();
        rst = 0;
        chk("rst2_outputs", 64'(all_out), 0);

        // continuous contention, four writes each
        m0_req = 1; m0_we = 1; m0_addr = 6'h01; m0_wdata = 8'h11;
        m1_req = 1; m1_we = 1; m1_addr = 6'h02; m1_wdata = 8'h22;
        for (int i = 0; i < 8; i++) begin
            logic odd;
            odd = (i % 2 == 1);
            tick();
            chk("c_write", 64'(write), 1);
            chk("c_gnt", 64'({m0_gnt, m1_gnt}), odd ? 'b01 : 'b10);
            chk("c_addr", 64'(addr), odd ? 'h02 : 'h01);
            chk("c_wdata", 64'(data_write), odd ? 'h22 : 'h11);
            tick();
            chk("c_done", 64'({m0_done, m1_done}), odd ? 'b01 : 'b10);
            if (i == 7) begin
                m0_req = 0; m1_req = 0;
            end
            tick();
            chk("c_idle", 64'({m0_gnt, m1_gnt, busy, write}), 0);
        end
        tick();
        chk("c_stop", 64'(busy), 0);

        // mid-transaction field change: m0 read of 0x0A, then fields change
        m0_req = 1; m0_we = 0; m0_addr = 6'h0A; data_read = 8'h99;
        tick();
        chk("m_strobe", 64'({read, write, addr}), {2'b10, 6'h0A});
        m0_req = 0; m0_we = 1; m0_addr = 6'h3F; m0_wdata = 8'hFF;
        tick();
        chk("m_wait1", 64'({read, write, addr}), {2'b00, 6'h0A});
        tick();
        chk("m_wait2", 64'({read, write, addr}), {2'b00, 6'h0A});
        tick();
        chk("m_done", 64'({m0_done, m1_done}), 'b10);
        chk("m_rdata", 64'(m0_rdata), 'h99);
        tick();
        chk("m_end", 64'({m0_gnt, busy, read, write}), 0);

        // reset during WAIT: pointer currently favours m1
        m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 1; m1_we = 0; m1_addr = 6'h20; data_read = 8'h55;
        tick();
        chk("x_strobe", 64'({read, m1_gnt}), 'b11);
        tick();
        chk("x_wait", 64'({m1_done, read}), 0);
        rst = 1;
        tick();
        rst = 0;
        chk("x_reset_outputs", 64'(all_out), 0);
        m0_req = 1; m0_we = 1; m0_addr = 6'h04; m0_wdata = 8'h44;
        tick();
        chk("x_gnt_m0", 64'({m0_gnt, m1_gnt}), 'b10);
        chk("x_no_done", 64'({m0_done, m1_done}), 0);
        chk("x_addr", 64'(addr), 'h04);
        tick();
        chk("x_m0_done", 64'({m0_done, m1_done}), 'b10);
        m0_req = 0;
        tick();
        tick();
        chk("x_gnt_m1", 64'({m0_gnt, m1_gnt, read}), 'b011);
        chk("x_m1_addr", 64'(addr), 'h20);
        tick();
        tick();
        tick();
        chk("x_m1_done", 64'({m1_done, m1_rdata}), {1'b1, 8'h55});
        m1_req = 0;
        tick();
        chk("x_end", 64'(busy), 0);

        // back-to-back accesses from m0 with req held across done
        m0_req = 1; m0_we = 1; m0_addr = 6'h03; m0_wdata = 8'h33;
        tick();
        chk("b_first", 64'({m0_gnt, write, addr}), {2'b11, 6'h03});
        tick();
        chk("b_done", 64'(m0_done), 1);
        tick();
        chk("b_idle", 64'({busy, write, m0_gnt}), 0);
        tick();
        chk("b_second", 64'({m0_gnt, write, data_write}), {2'b11, 8'h33});
        m0_req = 0;
        tick();
        chk("b_done2", 64'(m0_done), 1);
        tick();
        chk("b_end", 64'(busy), 0);

        // RD_LATENCY=0: data_read captured at the edge that ends the strobe cycle
        z_req = 1; z_we = 0; z_addr = 6'h07; z_data_read = 8'hC3;
        tick();
        chk("z_strobe", 64'({z_read, z_write, z_addr_o}), {2'b10, 6'h07});
        tick();
        chk("z_done", 64'({z_m0_done, z_m0_rdata}), {1'b1, 8'hC3});
        chk("z_bus_idle", 64'({z_read, z_addr_o}), 0);
        z_req = 0; z_data_read = 8'h00;
        tick();
        chk("z_hold", 64'({z_m0_done, z_busy, z_m0_rdata}), {2'b00, 8'hC3});
        chk("z_m1_quiet", 64'({z_m1_gnt, z_m1_done, z_m1_rdata}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // one-hot grant and exclusive strobes, checked every cycle
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(m0_gnt && m1_gnt) && !(read && write))
            else begin
                nerr++;
                $error("FAIL exclusivity: gnt=%b%b strobes=%b%b expected no overlap",
                       m0_gnt, m1_gnt, read, write);
            end
        end
    end

endmodule
